// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator command front end.
// Control-FSM state codes, op codes and the front-end state encoding.
package calc_pkg;

    localparam logic [3:0] CS_IDLE    = 4'h0;
    localparam logic [3:0] CS_R1WRITE = 4'h1;
    localparam logic [3:0] CS_DONE    = 4'h8;

    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2,
        S_HOLD  = 2'd3
    } fe_state_e;

endpackage

// File: rtl/calc_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, stability counter and
// a registered one-cycle pulse on each rising edge of the debounced level.
module calc_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic btn_raw,
    output logic db,
    output logic press
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips on the DB_CYCLES-th consecutive disagreeing cycle.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        db_d    = db_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d    = ~db_q;
                press_d = ~db_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q  <= '0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            db_q    <= db_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db    = db_q;
    assign press = press_q;

endmodule

// File: rtl/calc_cmd_front.sv
// Calculator command front end: debounced Go, operand snapshot, result capture.
// Optional watchdog on command completion enabled by defining CALC_TIMEOUT_EN.
module calc_cmd_front
    import calc_pkg::*;
#(
    parameter int unsigned DW        = 4,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned TIMEOUT   = 32
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          btn_go,
    input  logic [1:0]    sw_op,
    input  logic [DW-1:0] sw_a,
    input  logic [DW-1:0] sw_b,
    input  logic [3:0]    fsm_cs,
    input  logic [DW-1:0] alu_out,
    output logic          Go,
    output logic [1:0]    Op,
    output logic [DW-1:0] In1,
    output logic [DW-1:0] In2,
    output logic [DW-1:0] result,
    output logic          result_valid,
    output logic          busy,
    output logic          err
);

    fe_state_e     state_q, state_d;
    logic          go_q, go_d;
    logic          busy_q, busy_d;
    logic [1:0]    op_q, op_d;
    logic [DW-1:0] in1_q, in1_d;
    logic [DW-1:0] in2_q, in2_d;
    logic [DW-1:0] result_q, result_d;
    logic          rv_q, rv_d;
    logic          err_q, err_d;
    logic          db, press;
    logic          tmo_hit;

    calc_debounce #(.DB_CYCLES(DB_CYCLES)) u_debounce (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .btn_raw (btn_go),
        .db      (db),
        .press   (press)
    );

`ifdef CALC_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmo_q, tmo_d;

    // Counts cycles since Go rose; cleared whenever no command is pending.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_ISSUE || state_q == S_RUN) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end

    assign tmo_hit = (state_q == S_ISSUE || state_q == S_RUN) &&
                     (tmo_q == TW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        go_d     = go_q;
        busy_d   = busy_q;
        op_d     = op_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        result_d = result_q;
        rv_d     = rv_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    state_d = S_ISSUE;
                    go_d    = 1'b1;
                    busy_d  = 1'b1;
                    op_d    = sw_op;
                    in1_d   = sw_a;
                    in2_d   = sw_b;
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                // A DONE seen here must still drop Go so the 8->0 return cannot relaunch.
                if (fsm_cs == CS_DONE) begin
                    state_d  = S_HOLD;
                    go_d     = 1'b0;
                    result_d = alu_out;
                    rv_d     = 1'b1;
                end else if (fsm_cs == CS_R1WRITE) begin
                    state_d = S_RUN;
                    go_d    = 1'b0;
                end else if (tmo_hit) begin
                    state_d = S_HOLD;
                    go_d    = 1'b0;
                    err_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (fsm_cs == CS_DONE) begin
                    state_d  = S_HOLD;
                    result_d = alu_out;
                    rv_d     = 1'b1;
                end else if (tmo_hit) begin
                    state_d = S_HOLD;
                    err_d   = 1'b1;
                end
            end
            S_HOLD: begin
                if (fsm_cs == CS_IDLE && !db) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                go_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q  <= S_IDLE;
            go_q     <= 1'b0;
            busy_q   <= 1'b0;
            op_q     <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            go_q     <= go_d;
            busy_q   <= busy_d;
            op_q     <= op_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
        end
    end

    assign Go           = go_q;
    assign busy         = busy_q;
    assign Op           = op_q;
    assign In1          = in1_q;
    assign In2          = in2_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign err          = err_q;

endmodule

// File: tb/tb_calc_cmd_front.sv
// Scoreboard bench for calc_cmd_front: expected commands/results are queued
// by the stimulus and popped by a monitor on each Go / result_valid rise.
module tb_calc_cmd_front;

    localparam int unsigned DW  = 4;
    localparam int unsigned DBC = 4;
    localparam int unsigned TMO = 32;

    logic          CLK = 1'b0;
    logic          RST_n;
    logic          btn_go;
    logic [1:0]    sw_op;
    logic [DW-1:0] sw_a, sw_b;
    logic [3:0]    fsm_cs;
    logic [DW-1:0] alu_out;
    logic          Go;
    logic [1:0]    Op;
    logic [DW-1:0] In1, In2, result;
    logic          result_valid, busy, err;

    calc_cmd_front #(.DW(DW), .DB_CYCLES(DBC), .TIMEOUT(TMO)) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .btn_go       (btn_go),
        .sw_op        (sw_op),
        .sw_a         (sw_a),
        .sw_b         (sw_b),
        .fsm_cs       (fsm_cs),
        .alu_out      (alu_out),
        .Go           (Go),
        .Op           (Op),
        .In1          (In1),
        .In2          (In2),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2*DW+1:0] exp_cmd_q[$];
    logic [DW-1:0]   exp_res_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every Go rise must match a queued command, every result_valid rise a queued result.
    logic            go_prev = 1'b0;
    logic            rv_prev = 1'b0;
    logic [2*DW+1:0] mon_cmd;
    logic [DW-1:0]   mon_res;
    always @(negedge CLK) begin
        if (Go === 1'b1 && go_prev !== 1'b1) begin
            n_cmp++;
            if (exp_cmd_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_go: got op=%0h a=%0h b=%0h, expected no command", Op, In1, In2);
            end else begin
                mon_cmd = exp_cmd_q.pop_front();
                if ({Op, In1, In2} !== mon_cmd) begin
                    n_bad++;
                    $display("FAIL cmd_latch: got %0h, expected %0h", {Op, In1, In2}, mon_cmd);
                end
            end
        end
        if (result_valid === 1'b1 && rv_prev !== 1'b1) begin
            n_cmp++;
            if (exp_res_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got %0h, expected no result", result);
            end else begin
                mon_res = exp_res_q.pop_front();
                if (result !== mon_res) begin
                    n_bad++;
                    $display("FAIL result: got %0h, expected %0h", result, mon_res);
                end
            end
        end
        go_prev = Go;
        rv_prev = result_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_go(output int edges);
        edges = 0;
        do begin
            tick(1);
            edges++;
        end while (Go !== 1'b1 && edges < 40);
    endtask

    task automatic wait_busy_low(output int edges);
        edges = 0;
        do begin
            tick(1);
            edges++;
        end while (busy !== 1'b0 && edges < 40);
    endtask

    // Control-FSM model: 1 -> 2 -> 3 -> 7 -> 8 -> 0 with alu_out presented at DONE.
    task automatic run_cmd(input logic [DW-1:0] alu);
        fsm_cs = 4'h1;
        tick(1);
        check("go_fall_after_r1", Go, 0);
        check("busy_in_run", busy, 1);
        fsm_cs = 4'h2; tick(1);
        fsm_cs = 4'h3; tick(1);
        fsm_cs = 4'h7; tick(1);
        fsm_cs = 4'h8; alu_out = alu;
        tick(1);
        check("result_at_done", result, 32'(alu));
        check("rv_at_done", result_valid, 1);
        fsm_cs = 4'h0; alu_out = '0;
        tick(1);
        check("go_low_after_done", Go, 0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] res);
        sw_op = op; sw_a = a; sw_b = b;
        exp_cmd_q.push_back({op, a, b});
        exp_res_q.push_back(res);
        btn_go = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        int e;
        RST_n = 1'b0; btn_go = 1'b0; sw_op = '0; sw_a = '0; sw_b = '0;
        fsm_cs = 4'h0; alu_out = '0;
        #2;
        check("reset_outputs", {Go, Op, In1, In2, result, result_valid, busy, err}, 0);
        tick(3);
        RST_n = 1'b1;
        tick(3);
        check("idle_after_reset", {Go, busy, err}, 0);

        // Clean ADD 3+5, button held through DONE and Idle.
        issue(2'b11, 4'h3, 4'h5, 4'h8);
        wait_go(e);
        check("go_latency", e, DBC + 3);
        check("busy_on_go", busy, 1);
        run_cmd(4'h8);
        tick(10);
        check("busy_held_while_btn", busy, 1);
        check("no_reissue_held", Go, 0);
        btn_go = 1'b0;
        wait_busy_low(e);
        check("busy_fall_latency", e, DBC + 3);
        check("result_kept", result, 8);

        // Short glitch then bounce: no press; then a stable SUB 9-4.
        sw_op = 2'b10; sw_a = 4'h9; sw_b = 4'h4;
        btn_go = 1'b1; tick(DBC - 1);
        btn_go = 1'b0; tick(2);
        btn_go = 1'b1; tick(2);
        btn_go = 1'b0; tick(1);
        btn_go = 1'b1; tick(3);
        btn_go = 1'b0; tick(12);
        check("glitch_no_go", Go, 0);
        check("glitch_not_busy", busy, 0);
        issue(2'b10, 4'h9, 4'h4, 4'h5);
        wait_go(e);
        check("go_latency_2", e, DBC + 3);
        run_cmd(4'h5);
        btn_go = 1'b0;
        wait_busy_low(e);
        check("busy_low_2", busy, 0);

        // AND C&A with switch changes and a second press mid-command.
        issue(2'b01, 4'hC, 4'hA, 4'h8);
        wait_go(e);
        btn_go = 1'b0;
        fsm_cs = 4'h1;
        tick(1);
        check("go_fall_3", Go, 0);
        sw_op = 2'b00; sw_a = 4'hF;
        fsm_cs = 4'h2;
        tick(2);
        check("op_stable", Op, 32'h1);
        check("in1_stable", In1, 32'hC);
        check("in2_stable", In2, 32'hA);
        btn_go = 1'b1; tick(8);
        btn_go = 1'b0; tick(8);
        check("busy_press_dropped", Go, 0);
        fsm_cs = 4'h3; tick(1);
        fsm_cs = 4'h7; tick(1);
        fsm_cs = 4'h8; alu_out = 4'h8;
        tick(1);
        check("result_3", result, 8);
        fsm_cs = 4'h0; alu_out = '0;
        wait_busy_low(e);
        check("busy_fall_released", e, 1);

`ifdef CALC_TIMEOUT_EN
        // Watchdog: FSM stuck at 3 never acknowledges.
        issue(2'b00, 4'h1, 4'h2, 4'h3);
        exp_res_q.delete();
        wait_go(e);
        fsm_cs = 4'h3;
        e = 0;
        do begin
            tick(1);
            e++;
        end while (err !== 1'b1 && e < TMO + 10);
        check("timeout_cycles", e, TMO);
        check("timeout_go_low", Go, 0);
        check("timeout_rv_low", result_valid, 0);
        check("timeout_busy", busy, 1);
        fsm_cs = 4'h0;
        btn_go = 1'b0;
        wait_busy_low(e);
        check("timeout_err_sticky", err, 1);
        issue(2'b00, 4'h1, 4'h2, 4'h3);
        wait_go(e);
        check("err_cleared", err, 0);
        run_cmd(4'h3);
        btn_go = 1'b0;
        wait_busy_low(e);
`endif

        // Reset in the middle of a command, then a fresh press.
        issue(2'b11, 4'h7, 4'h7, 4'hE);
        exp_res_q.delete();
        wait_go(e);
        fsm_cs = 4'h1; tick(1);
        fsm_cs = 4'h2; tick(2);
        @(posedge CLK);
        #3 RST_n = 1'b0;
        #1;
        check("async_reset_outputs", {Go, Op, In1, In2, result, result_valid, busy, err}, 0);
        btn_go = 1'b0; fsm_cs = 4'h0;
        tick(2);
        RST_n = 1'b1;
        tick(20);
        check("no_go_after_reset", Go, 0);
        check("idle_after_reset_2", busy, 0);
        issue(2'b11, 4'h7, 4'h7, 4'hE);
        wait_go(e);
        check("go_latency_post_reset", e, DBC + 3);
        run_cmd(4'hE);
        btn_go = 1'b0;
        wait_busy_low(e);

        tick(5);
        check("cmd_queue_drained", exp_cmd_q.size(), 0);
        check("res_queue_drained", exp_res_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
